// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter using the double-dabble (shift-add-3)
//   algorithm, one iteration per clock. It optionally treats the input as
//   two's complement and converts the magnitude. It reports the sign separately.
//
// Parameters
//   WIDTH  : binary input width (4..32)
//   DIGITS : number of BCD output digits; 10**DIGITS must exceed 2**WIDTH-1
//
// Ports
//   clk       : clock, rising-edge active
//   rst       : asynchronous active-high reset
//   start     : conversion request, accepted only in IDLE or DONE
//   bin_in    : value to convert, captured when start is accepted
//   is_signed : 1 = bin_in is two's complement, captured with bin_in
//   busy      : high while a conversion is running
//   done      : one-cycle pulse when bcd_out/neg carry a fresh result
//   bcd_out   : packed BCD magnitude, most significant digit in the top nibble
//   neg       : sign of the last result (1 = negative)

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  // The power of ten stops growing once it passes the limit so it never overflows.
  function automatic bit digits_ok(input int w, input int d);
    longint limit;
    longint p;
    limit = (longint'(1) << w) - 1;
    p = 1;
    for (int i = 0; i < d; i++) begin
      if (p <= limit) p = p * 10;
    end
    return p > limit;
  endfunction

  // Reject parameter combinations that could not hold the result
  if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
    $error("bin2bcd_seq: WIDTH=%0d outside legal range 4..32", WIDTH);
  end
  if (!digits_ok(WIDTH, DIGITS)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_reg;
  logic [BW-1:0]    bcd_reg;
  logic [CW-1:0]    cnt;
  logic             sign_reg;

  logic             sign_in;
  logic [WIDTH-1:0] mag_in;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_next;
  logic [WIDTH-1:0] mag_next;

  // Capture-side decode. The magnitude register is unsigned and WIDTH bits wide,
  // so negating the most negative value gives 2**(WIDTH-1) without loss.
  always_comb begin
    sign_in = is_signed & bin_in[WIDTH-1];
    mag_in  = sign_in ? (~bin_in + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_in;
  end

  // One double-dabble step. Each digit >= 5 first gets 3 added. Then the
  // {BCD, magnitude} pair shifts left by one, and the magnitude MSB enters
  // the BCD LSB.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[BW-2:0], mag_reg[WIDTH-1]};
    mag_next = {mag_reg[WIDTH-2:0], 1'b0};
  end

  // Control FSM and datapath registers. Starting from IDLE or DONE loads a
  // fresh operand. SHIFT runs exactly WIDTH iterations. The last iteration
  // publishes the result and raises done for one cycle. A start seen in
  // SHIFT falls through the SHIFT branch and so is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag_reg  <= '0;
      bcd_reg  <= '0;
      cnt      <= '0;
      sign_reg <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mag_reg  <= mag_in;
            sign_reg <= sign_in;
            bcd_reg  <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          mag_reg <= mag_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd_out <= bcd_next;
            neg     <= sign_reg;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//   Scoreboard bench for bin2bcd_seq (WIDTH=8, DIGITS=3). The stimulus pushes
//   the expected {neg, bcd} for every accepted request. A monitor pops it and
//   compares it on each done pulse. The reference model does plain decimal
//   arithmetic on the operand.

module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  bin_in;
  logic              is_signed;
  logic              busy;
  logic              done;
  logic [11:0]       bcd_out;
  logic              neg;

  logic [12:0]       exp_q[$];
  int                checks = 0;
  int                fails  = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .neg       (neg)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: take the signed or unsigned value and split it into decimal digits
  function automatic logic [12:0] model(input logic [7:0] v, input logic s);
    int         m;
    logic       n;
    logic [3:0] h, t, o;
    n = s & v[7];
    m = n ? 256 - int'(v) : int'(v);
    h = 4'(m / 100);
    t = 4'((m / 10) % 10);
    o = 4'(m % 10);
    return {n, h, t, o};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one accepted request. The operand inputs are scrambled afterwards
  // to show that only the value present at acceptance matters.
  task automatic applyStimulus(input logic [7:0] v, input logic s);
    @(negedge clk);
    bin_in    = v;
    is_signed = s;
    start     = 1'b1;
    exp_q.push_back(model(v, s));
    @(negedge clk);
    start     = 1'b0;
    bin_in    = 8'($urandom);
    is_signed = 1'($urandom);
  endtask

  // Step negedges until done, reporting the cycles taken and the cycles with busy high
  task automatic waitDone(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 20 cycles");
    end
  endtask

  // Monitor: check that busy and done are never high together. On each done
  // pulse, check the result against the scoreboard. Between pulses, check
  // that the published result holds still.
  initial begin
    logic [12:0] e;
    logic [12:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
      end else begin
        checkOutput("busy_done_exclusive", 32'(busy & done), 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_done: got done with bcd %0h, expected no done", bcd_out);
          end else begin
            e = exp_q.pop_front();
            checkOutput("bcd_out", 32'(bcd_out), 32'(e[11:0]));
            checkOutput("neg", 32'(neg), 32'(e[12]));
            for (int d = 0; d < DIGITS; d++) begin
              checkOutput("digit_range", 32'(bcd_out[4*d +: 4] <= 4'd9), 32'd1);
            end
          end
          last = {neg, bcd_out};
        end else begin
          checkOutput("result_hold", 32'({neg, bcd_out}), 32'(last));
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int cyc, bcyc, cnt_done, cnt_busy;
    logic [7:0] rv;
    logic       rs;
    rst = 1'b1; start = 1'b0; bin_in = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
    checkOutput("reset_neg", 32'(neg), 32'd0);
    rst = 1'b0;

    // Unsigned max: latency and busy width
    applyStimulus(8'hFF, 1'b0);
    waitDone(cyc, bcyc);
    checkOutput("latency_ff", cyc, 8);
    checkOutput("busy_cycles_ff", bcyc, 8);

    // Signed corner cases, zero, and a small value
    applyStimulus(8'h80, 1'b1); waitDone(cyc, bcyc); checkOutput("latency_80s", cyc, 8);
    applyStimulus(8'hFF, 1'b1); waitDone(cyc, bcyc); checkOutput("latency_ffs", cyc, 8);
    applyStimulus(8'h7F, 1'b1); waitDone(cyc, bcyc); checkOutput("latency_7fs", cyc, 8);
    applyStimulus(8'h00, 1'b0); waitDone(cyc, bcyc); checkOutput("latency_00", cyc, 8);
    applyStimulus(8'h09, 1'b0); waitDone(cyc, bcyc); checkOutput("latency_09", cyc, 8);

    // A start pulsed mid-conversion is ignored, and no second done follows
    applyStimulus(8'd200, 1'b0);
    repeat (2) @(negedge clk);
    bin_in = 8'd17; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc, bcyc);
    checkOutput("ignored_start_latency", cyc, 5);
    cnt_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    checkOutput("no_second_done", cnt_done, 0);
    checkOutput("idle_after_200", 32'(busy), 32'd0);

    // Reset mid-conversion clears everything at once and aborts the run
    applyStimulus(8'd123, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1; start = 1'b1; bin_in = 8'd77;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_bcd", 32'(bcd_out), 32'd0);
    checkOutput("async_rst_neg", 32'(neg), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0; start = 1'b0;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    checkOutput("no_done_after_rst", cnt_done, 0);
    checkOutput("no_busy_after_rst", cnt_busy, 0);
    applyStimulus(8'd42, 1'b0);
    waitDone(cyc, bcyc);
    checkOutput("latency_42", cyc, 8);

    // Back-to-back conversions with start held through the done cycle
    @(negedge clk);
    bin_in = 8'd99; is_signed = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'd99, 1'b0));
    @(negedge clk);
    waitDone(cyc, bcyc);
    checkOutput("latency_99", cyc, 8);
    bin_in = 8'd100;
    exp_q.push_back(model(8'd100, 1'b0));
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone(cyc, bcyc);
    checkOutput("b2b_done_gap", cyc + 1, 9);

    // Randomised operands and signedness
    for (int k = 0; k < 25; k++) begin
      rv = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      applyStimulus(rv, rs);
      waitDone(cyc, bcyc);
      checkOutput("latency_rand", cyc, 8);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count; must satisfy 10^DIGITS > 2^WIDTH - 1, or a simulation-time $error is raised.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1: request to convert bin_in, sampled on a rising edge.
REQ-006 SHALL have port bin_in  input  WIDTH: value to convert, captured only when start is accepted.
REQ-007 SHALL have port is_signed  input  1: 1 = treat bin_in as two's complement, 0 = unsigned; captured with bin_in.
REQ-008 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-009 SHALL have port done  output  1: single-cycle pulse marking a valid result.
REQ-010 SHALL have port bcd_out  output  4*DIGITS: packed BCD magnitude, most significant digit in the top nibble.
REQ-011 SHALL have port neg  output  1: sign of the last result (1 = negative).

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE; the reset state is IDLE.
REQ-013 SHALL accept start only in IDLE or DONE; start asserted in SHIFT SHALL be ignored, with no effect on the running conversion.
REQ-014 On acceptance at edge t0, SHALL latch the magnitude and sign, enter SHIFT, and clear the shift counter.
- Magnitude: if is_signed=1 and bin_in[WIDTH-1]=1, magnitude = two's-complement negation of bin_in; otherwise magnitude = bin_in.
- Sign: sign = is_signed & bin_in[WIDTH-1].
REQ-015 SHALL convert the most negative signed value (e.g. 8'h80) to magnitude 2^(WIDTH-1) without loss, using an unsigned WIDTH-bit magnitude register.
REQ-016 SHALL perform one double-dabble iteration per SHIFT cycle, at edges t1..tWIDTH:
- first, add 3 to every BCD digit that is >= 5;
- then shift the {BCD, magnitude} register left by 1.
REQ-017 SHALL leave SHIFT after exactly WIDTH iterations; at edge tWIDTH it SHALL load bcd_out and neg, assert done, and enter DONE.
REQ-018 SHALL hold done high for exactly one cycle, from edge tWIDTH to edge tWIDTH+1; latency from the accepting edge to done is WIDTH cycles.
REQ-019 SHALL drive busy high from edge t0 until edge tWIDTH, and low in IDLE and DONE; busy and done are never high together.
REQ-020 In DONE, SHALL go to SHIFT on start=1 (back-to-back conversion, with done low on the next cycle) and to IDLE otherwise.
REQ-021 SHALL hold bcd_out and neg stable between done pulses; they change only at the edge that raises done.
REQ-022 SHALL produce every BCD digit in 0..9; no digit ever exceeds 4'h9.

Reset
REQ-023 On rst=1, asynchronously and without waiting for a clock edge, SHALL set:
- state = IDLE;
- busy = 0, done = 0, neg = 0;
- bcd_out = 0;
- all internal shift and counter registers = 0.
REQ-024 Reset asserted mid-conversion SHALL abort that conversion: no done pulse follows, and the first accepted start after rst deasserts begins a fresh conversion.
REQ-025 While rst=1, SHALL ignore start.

Verification (WIDTH=8, DIGITS=3)
REQ-026 SHALL cover: unsigned bin_in=8'hFF, start for 1 cycle -> done exactly 8 cycles after the accepting edge; bcd_out=12'h255, neg=0; busy high for 8 cycles.
REQ-027 SHALL cover: is_signed=1 with bin_in=8'h80 -> bcd_out=12'h128, neg=1; with 8'hFF -> 12'h001, neg=1; with 8'h7F -> 12'h127, neg=0.
REQ-028 SHALL cover: unsigned bin_in=8'h00 -> bcd_out=12'h000, neg=0, done after 8 cycles; then unsigned 8'h09 -> 12'h009.
REQ-029 SHALL cover: start pulsed again 3 cycles into a conversion of 8'd200 with bin_in=8'd17 -> result 12'h200, then return to IDLE with no second done.
REQ-030 SHALL cover: rst pulsed 4 cycles into a conversion -> busy, done, bcd_out and neg at 0 immediately; no done follows; next start with 8'd42 -> 12'h042 after 8 cycles.
REQ-031 SHALL cover: start held high through the done cycle with 8'd99 then 8'd100 -> two done pulses 9 cycles apart, with results 12'h099 then 12'h100.
